conv_compute: RTL and testbench
===============================

// Module: conv_compute
// PURPOSE
//  Convolution engine directly downstream of the input memory stage. Once inputs_loaded is high,
//  walks every valid output position of Y = B + sum_ij X[r+i][c+j]*W[i][j] (size (R-K+1)x(C-K+1)).
//  Reads X/W through the memories' synchronous read ports, and MACs one tap per cycle.
//  Streams results row-major on an AXIS master, then pulses compute_finished to release the memories.
// PARAMETERS
//  INW   24  input data width (signed), matches memory stage
//  R     9   rows of X (>=3)
//  C     8   cols of X (>=3)
//  MAXK  4   max weight dimension
//  (local) OUTW = 2*INW+$clog2(MAXK*MAXK) = 52; K_BITS, X_ADDR_BITS, W_ADDR_BITS as in memory stage
// PORTS
//  clk              in   1            system clock
//  reset            in   1            synchronous, active-high
//  inputs_loaded    in   1            memories hold valid X, W, K, B
//  K                in   K_BITS       weight dimension
//  B                in   INW          signed bias
//  X_read_addr      out  X_ADDR_BITS  X address, row-major r*C+c
//  X_data           in   INW          signed, valid 1 cycle after address
//  W_read_addr      out  W_ADDR_BITS  W address, row-major i*K+j
//  W_data           in   INW          signed, valid 1 cycle after address
//  compute_finished out  1            1-cycle pulse after last output accepted
//  AXIS_TDATA       out  OUTW         signed result
//  AXIS_TVALID      out  1            result valid
//  AXIS_TREADY      in   1            downstream ready
// BEHAVIOUR
//  Reset: state IDLE; AXIS_TVALID=0, AXIS_TDATA=0, compute_finished=0, addresses=0, counters/acc=0.
//   Reset mid-operation aborts immediately; no partial output, no finished pulse.
//  States: IDLE -> MAC -> DRAIN -> OUT -> (MAC | DONE) -> RELEASE -> IDLE.
//  IDLE: on inputs_loaded=1, latch K,B into regs; clear out_r,out_c; go MAC.
//   If latched K==0, K>R or K>C: go DONE directly (zero outputs).
//  MAC: K*K cycles; cycle n issues tap (i,j)=(n/K, n%K): X addr (out_r+i)*C+out_c+j, W addr i*K+j.
//  Pipeline: cycle t addr -> t+1 data, product registered -> t+2 acc += product.
//   acc preloaded with sign-extended B on MAC entry. DRAIN = 2 cycles.
//  Latency: AXIS_TVALID rises exactly K*K+2 cycles after first MAC cycle of each pixel.
//  OUT: AXIS_TVALID=1, TDATA=acc, both held stable until TVALID&&TREADY.
//   No new issue while stalled. On handshake: advance out_c; wrap to 0 and out_r++ at C-K.
//   If last position (R-K, C-K): go DONE; else go MAC (TVALID=0 next cycle).
//  DONE: compute_finished=1 for exactly one cycle; go RELEASE.
//  RELEASE: wait for inputs_loaded=0, then IDLE (prevents re-run on stale inputs_loaded).
//  Arithmetic: signed INWxINW -> 2*INW product, sign-extended to OUTW; acc OUTW; no saturation.
//  K/B changes on ports mid-run ignored (latched copies used).
//  TREADY high while TVALID low has no effect.
// STRUCTURE
//  conv_pkg: state_t enum, OUTW/addr-width localparams-as-functions shared with testbench.
//  Sub-module conv_mac: product register + accumulator (load_bias, en, signed ports).
//  Top holds FSM, (out_r,out_c,i,j) counters, address gen.
// TESTING
//  K=1, W=[2], B=0, X=1..72 -> 72 outputs 2,4..144 row-major; one compute_finished.
//  K=3, W all 1, B=-5, X all 1 -> 42 outputs each 4; TVALID first at cycle 11 after MAC entry.
//  K=4, X,W all -2^23, B=2^23-1 -> 30 outputs each 2^50+2^23-1; checks OUTW sign/width.
//  K=2 random X/W/B, TREADY random ~30% -> TDATA stable while stalled; matches golden model.
//  Reset asserted mid-pixel during MAC of output 5 -> TVALID=0 next cycle, no finished pulse; rerun matches golden.
//  K=0 latched -> no TVALID ever; compute_finished pulses once; RELEASE holds until inputs_loaded=0.

Source files
------------

// File: rtl/conv_pkg.sv
// conv_pkg: shared types and width helpers for the convolution engine.
//   state_t          : FSM state encoding of conv_compute
//   calc_outw        : accumulator/result width, 2*INW + log2(MAXK*MAXK) guard bits
//   calc_k_bits      : width of the K port (must hold 0..MAXK)
//   calc_x_addr_bits : X memory address width for an R x C input
//   calc_w_addr_bits : W memory address width for a MAXK x MAXK kernel
package conv_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_MAC,
      S_DRAIN,
      S_OUT,
      S_DONE,
      S_RELEASE
   } state_t;

   function automatic int calc_outw(input int inw, input int maxk);
      return 2 * inw + $clog2(maxk * maxk);
   endfunction

   function automatic int calc_k_bits(input int maxk);
      return $clog2(maxk + 1);
   endfunction

   function automatic int calc_x_addr_bits(input int r, input int c);
      return $clog2(r * c);
   endfunction

   function automatic int calc_w_addr_bits(input int maxk);
      return $clog2(maxk * maxk);
   endfunction

endpackage

// File: rtl/conv_mac.sv
// conv_mac: registered signed multiplier followed by an accumulator.
//   clk, reset : clock, synchronous active-high reset
//   load_bias  : preload acc with sign-extended bias (start of a pixel)
//   bias       : signed bias, INW bits
//   en         : a/b carry a valid tap this cycle
//   a, b       : signed operands, INW bits
//   acc        : signed running sum, OUTW bits
// The product lands one cycle after en and is added the cycle after that.
module conv_mac #(
   parameter int INW  = 24,
   parameter int OUTW = 52
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   load_bias,
   input  logic signed [INW-1:0]  bias,
   input  logic                   en,
   input  logic signed [INW-1:0]  a,
   input  logic signed [INW-1:0]  b,
   output logic signed [OUTW-1:0] acc
);

   localparam int PW = 2 * INW;

   logic signed [PW-1:0] prod;
   logic                 prod_v;

   // NOTE: state is updated with non-blocking assignments so every register
   // samples the values from before the edge, regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         prod   <= '0;
         prod_v <= 1'b0;
         acc    <= '0;
      end else begin
         prod_v <= en;
         if (en)
            prod <= PW'(a) * PW'(b);
         // load_bias only occurs between pixels, when no product is in flight
         if (load_bias)
            acc <= {{(OUTW-INW){bias[INW-1]}}, bias};
         else if (prod_v)
            acc <= acc + {{(OUTW-PW){prod[PW-1]}}, prod};
      end
   end

endmodule

// File: rtl/conv_compute.sv
// conv_compute: walks every valid output position of a KxK convolution over
// an R x C input held in synchronous-read memories, one tap per cycle, and
// streams results row-major on an AXI-Stream master.
//   clk, reset        : clock, synchronous active-high reset
//   inputs_loaded     : memories hold valid X, W, K, B
//   K, B              : kernel size and signed bias (latched at start)
//   X_read_addr/X_data: X memory port, data one cycle after address
//   W_read_addr/W_data: W memory port, data one cycle after address
//   compute_finished  : one-cycle pulse after the last result is accepted
//   AXIS_TDATA/TVALID/TREADY : result stream
module conv_compute
   import conv_pkg::*;
#(
   parameter  int INW         = 24,
   parameter  int R           = 9,
   parameter  int C           = 8,
   parameter  int MAXK        = 4,
   localparam int OUTW        = calc_outw(INW, MAXK),
   localparam int K_BITS      = calc_k_bits(MAXK),
   localparam int X_ADDR_BITS = calc_x_addr_bits(R, C),
   localparam int W_ADDR_BITS = calc_w_addr_bits(MAXK)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   inputs_loaded,
   input  logic [K_BITS-1:0]      K,
   input  logic [INW-1:0]         B,
   output logic [X_ADDR_BITS-1:0] X_read_addr,
   input  logic [INW-1:0]         X_data,
   output logic [W_ADDR_BITS-1:0] W_read_addr,
   input  logic [INW-1:0]         W_data,
   output logic                   compute_finished,
   output logic [OUTW-1:0]        AXIS_TDATA,
   output logic                   AXIS_TVALID,
   input  logic                   AXIS_TREADY
);

   localparam int ROW_BITS = $clog2(R);
   localparam int COL_BITS = $clog2(C);

   state_t              state;
   logic [K_BITS-1:0]   k_r;
   logic [INW-1:0]      b_r;
   logic [ROW_BITS-1:0] out_r;
   logic [COL_BITS-1:0] out_c;
   logic [K_BITS-1:0]   tap_i;
   logic [K_BITS-1:0]   tap_j;
   logic                drain_cnt;
   logic                tap_v;

   logic                k_ok;
   logic [K_BITS-1:0]   k_last;
   logic                last_col;
   logic                last_row;
   logic                handshake;
   logic                start;
   logic                mac_load;
   logic [INW-1:0]      mac_bias;
   logic signed [OUTW-1:0] acc;

   // K is checked on the port in IDLE, the same cycle it is latched
   assign k_ok      = (K != '0) && (int'(K) <= R) && (int'(K) <= C);
   assign k_last    = k_r - K_BITS'(1);
   assign last_col  = int'(out_c) == C - int'(k_r);
   assign last_row  = int'(out_r) == R - int'(k_r);
   assign handshake = (state == S_OUT) && AXIS_TVALID && AXIS_TREADY;
   assign start     = (state == S_IDLE) && inputs_loaded && k_ok;

   // Bias is preloaded on the edge that enters MAC for each pixel
   assign mac_load  = start || (handshake && !(last_col && last_row));
   assign mac_bias  = (state == S_IDLE) ? B : b_r;

   // Addresses follow the tap counters, which are registered
   assign X_read_addr = X_ADDR_BITS'((int'(out_r) + int'(tap_i)) * C
                                     + int'(out_c) + int'(tap_j));
   assign W_read_addr = W_ADDR_BITS'(int'(tap_i) * int'(k_r) + int'(tap_j));

   assign AXIS_TDATA  = acc;

   always_ff @(posedge clk) begin
      if (reset) begin
         state            <= S_IDLE;
         k_r              <= '0;
         b_r              <= '0;
         out_r            <= '0;
         out_c            <= '0;
         tap_i            <= '0;
         tap_j            <= '0;
         drain_cnt        <= 1'b0;
         tap_v            <= 1'b0;
         AXIS_TVALID      <= 1'b0;
         compute_finished <= 1'b0;
      end else begin
         compute_finished <= 1'b0;
         tap_v            <= 1'b0;
         case (state)
            S_IDLE: begin
               if (inputs_loaded) begin
                  k_r   <= K;
                  b_r   <= B;
                  out_r <= '0;
                  out_c <= '0;
                  tap_i <= '0;
                  tap_j <= '0;
                  if (k_ok) begin
                     state <= S_MAC;
                  end else begin
                     state            <= S_DONE;
                     compute_finished <= 1'b1;
                  end
               end
            end
            S_MAC: begin
               // the tap addressed this cycle has data next cycle
               tap_v <= 1'b1;
               if (tap_j == k_last) begin
                  tap_j <= '0;
                  if (tap_i == k_last) begin
                     tap_i <= '0;
                     state <= S_DRAIN;
                  end else begin
                     tap_i <= tap_i + 1'b1;
                  end
               end else begin
                  tap_j <= tap_j + 1'b1;
               end
            end
            S_DRAIN: begin
               // two cycles: last data -> product -> accumulate
               if (drain_cnt) begin
                  drain_cnt   <= 1'b0;
                  AXIS_TVALID <= 1'b1;
                  state       <= S_OUT;
               end else begin
                  drain_cnt <= 1'b1;
               end
            end
            S_OUT: begin
               if (AXIS_TREADY) begin
                  AXIS_TVALID <= 1'b0;
                  if (last_col && last_row) begin
                     state            <= S_DONE;
                     compute_finished <= 1'b1;
                  end else begin
                     state <= S_MAC;
                     if (last_col) begin
                        out_c <= '0;
                        out_r <= out_r + 1'b1;
                     end else begin
                        out_c <= out_c + 1'b1;
                     end
                  end
               end
            end
            S_DONE: begin
               state <= S_RELEASE;
            end
            S_RELEASE: begin
               // a stale inputs_loaded must not start a second run
               if (!inputs_loaded)
                  state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   conv_mac #(
      .INW  (INW),
      .OUTW (OUTW)
   ) u_mac (
      .clk       (clk),
      .reset     (reset),
      .load_bias (mac_load),
      .bias      ($signed(mac_bias)),
      .en        (tap_v),
      .a         ($signed(X_data)),
      .b         ($signed(W_data)),
      .acc       (acc)
   );

endmodule

// File: tb/tb_conv_compute.sv
// tb_conv_compute: self-checking bench for conv_compute. Models the X/W
// memories with one-cycle synchronous reads and checks the result stream
// against a direct sum-of-products reference.
module tb_conv_compute;
   import conv_pkg::*;

   localparam int INW         = 24;
   localparam int R           = 9;
   localparam int C           = 8;
   localparam int MAXK        = 4;
   localparam int OUTW        = calc_outw(INW, MAXK);
   localparam int K_BITS      = calc_k_bits(MAXK);
   localparam int X_ADDR_BITS = calc_x_addr_bits(R, C);
   localparam int W_ADDR_BITS = calc_w_addr_bits(MAXK);
   localparam int BUDGET      = 4000;

   logic                   clk = 1'b0;
   logic                   reset;
   logic                   inputs_loaded;
   logic [K_BITS-1:0]      K;
   logic [INW-1:0]         B;
   logic [X_ADDR_BITS-1:0] X_read_addr;
   logic [INW-1:0]         X_data;
   logic [W_ADDR_BITS-1:0] W_read_addr;
   logic [INW-1:0]         W_data;
   logic                   compute_finished;
   logic [OUTW-1:0]        AXIS_TDATA;
   logic                   AXIS_TVALID;
   logic                   AXIS_TREADY;

   logic signed [INW-1:0] xmem [0:(1<<X_ADDR_BITS)-1];
   logic signed [INW-1:0] wmem [0:(1<<W_ADDR_BITS)-1];

   int n_cmp = 0;
   int n_bad = 0;

   longint got_q[$];
   longint exp_q[$];
   int     fin_cnt, stall_err, first_valid, extra_fin, extra_valid;
   bit     timed_out, aborted;

   conv_compute #(
      .INW  (INW),
      .R    (R),
      .C    (C),
      .MAXK (MAXK)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .inputs_loaded    (inputs_loaded),
      .K                (K),
      .B                (B),
      .X_read_addr      (X_read_addr),
      .X_data           (X_data),
      .W_read_addr      (W_read_addr),
      .W_data           (W_data),
      .compute_finished (compute_finished),
      .AXIS_TDATA       (AXIS_TDATA),
      .AXIS_TVALID      (AXIS_TVALID),
      .AXIS_TREADY      (AXIS_TREADY)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      X_data <= xmem[X_read_addr];
      W_data <= wmem[W_read_addr];
   end

   task automatic clear_mems();
      for (int n = 0; n < (1 << X_ADDR_BITS); n++) xmem[n] = '0;
      for (int n = 0; n < (1 << W_ADDR_BITS); n++) wmem[n] = '0;
   endtask

   // Reference: Y[r][c] = B + sum X[r+i][c+j]*W[i][j], row-major
   task automatic calc_golden(input int k, input longint b);
      longint s;
      exp_q.delete();
      if (k == 0 || k > R || k > C) return;
      for (int r = 0; r <= R - k; r++)
         for (int c = 0; c <= C - k; c++) begin
            s = b;
            for (int i = 0; i < k; i++)
               for (int j = 0; j < k; j++)
                  s += longint'(xmem[(r + i) * C + c + j]) * longint'(wmem[i * k + j]);
            exp_q.push_back(s);
         end
   endtask

   // Runs one job and records what the DUT produced; scenarios judge it.
   task automatic run_job(input int k, input longint b, input int ready_pct,
                          input int abort_after);
      logic            prev_stall;
      logic [OUTW-1:0] prev_data;
      int              abort_wait;
      K = K_BITS'(k);
      B = INW'(b);
      got_q.delete();
      fin_cnt = 0; stall_err = 0; first_valid = -1; timed_out = 1'b1;
      aborted = 1'b0; extra_fin = 0; extra_valid = 0;
      prev_stall = 1'b0; prev_data = '0; abort_wait = 0;
      for (int n = 0; n < BUDGET; n++) begin
         @(negedge clk);
         if (n == 0) inputs_loaded = 1'b1;
         if (n == 2) begin
            K = K_BITS'($urandom);
            B = INW'($urandom);
         end
         AXIS_TREADY = ($urandom_range(99) < ready_pct);
         if (prev_stall && (AXIS_TVALID !== 1'b1 || AXIS_TDATA !== prev_data))
            stall_err++;
         if (AXIS_TVALID === 1'b1 && first_valid < 0) first_valid = n;
         if (AXIS_TVALID === 1'b1 && AXIS_TREADY)
            got_q.push_back(longint'($signed(AXIS_TDATA)));
         prev_stall = (AXIS_TVALID === 1'b1) && !AXIS_TREADY;
         prev_data  = AXIS_TDATA;
         if (compute_finished === 1'b1) begin
            fin_cnt++;
            timed_out = 1'b0;
            break;
         end
         if (abort_after >= 0 && got_q.size() == abort_after) begin
            abort_wait++;
            if (abort_wait == 3) begin
               reset         = 1'b1;
               inputs_loaded = 1'b0;
               aborted       = 1'b1;
               timed_out     = 1'b0;
               break;
            end
         end
      end
      if (!aborted) begin
         for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            if (compute_finished === 1'b1) extra_fin++;
            if (AXIS_TVALID === 1'b1) extra_valid++;
         end
         inputs_loaded = 1'b0;
         AXIS_TREADY   = 1'b0;
         repeat (2) @(negedge clk);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; inputs_loaded = 1'b0; AXIS_TREADY = 1'b0; K = '0; B = '0;
      repeat (3) @(negedge clk);
      n_cmp++; if (AXIS_TVALID !== 1'b0) begin n_bad++; $display("FAIL reset_tvalid: got %b want 0", AXIS_TVALID); end
      n_cmp++; if (AXIS_TDATA !== '0) begin n_bad++; $display("FAIL reset_tdata: got %0h want 0", AXIS_TDATA); end
      n_cmp++; if (compute_finished !== 1'b0) begin n_bad++; $display("FAIL reset_finished: got %b want 0", compute_finished); end
      n_cmp++; if (X_read_addr !== '0) begin n_bad++; $display("FAIL reset_xaddr: got %0d want 0", X_read_addr); end
      n_cmp++; if (W_read_addr !== '0) begin n_bad++; $display("FAIL reset_waddr: got %0d want 0", W_read_addr); end
      reset = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_k1_ramp();
      clear_mems();
      for (int n = 0; n < R * C; n++) xmem[n] = INW'(n + 1);
      wmem[0] = 24'sd2;
      run_job(1, 0, 100, -1);
      n_cmp++; if (timed_out) begin n_bad++; $display("FAIL k1_timeout: got no finish want finish"); end
      n_cmp++; if (got_q.size() != 72) begin n_bad++; $display("FAIL k1_count: got %0d want 72", got_q.size()); end
      for (int n = 0; n < got_q.size() && n < 72; n++) begin
         n_cmp++;
         if (got_q[n] != 2 * (n + 1)) begin n_bad++; $display("FAIL k1_out[%0d]: got %0d want %0d", n, got_q[n], 2 * (n + 1)); end
      end
      n_cmp++; if (fin_cnt != 1 || extra_fin != 0) begin n_bad++; $display("FAIL k1_finished: got %0d want 1", fin_cnt + extra_fin); end
      n_cmp++; if (first_valid != 1 + 1 + 2) begin n_bad++; $display("FAIL k1_latency: got %0d want 4", first_valid); end
   endtask

   task automatic test_k3_latency();
      clear_mems();
      for (int n = 0; n < R * C; n++) xmem[n] = 24'sd1;
      for (int n = 0; n < 9; n++) wmem[n] = 24'sd1;
      run_job(3, -5, 100, -1);
      n_cmp++; if (got_q.size() != 42) begin n_bad++; $display("FAIL k3_count: got %0d want 42", got_q.size()); end
      for (int n = 0; n < got_q.size(); n++) begin
         n_cmp++;
         if (got_q[n] != 4) begin n_bad++; $display("FAIL k3_out[%0d]: got %0d want 4", n, got_q[n]); end
      end
      // loop index 0 is the IDLE cycle, MAC starts at index 1
      n_cmp++; if (first_valid - 1 != 11) begin n_bad++; $display("FAIL k3_latency: got %0d want 11", first_valid - 1); end
      n_cmp++; if (fin_cnt != 1 || extra_fin != 0) begin n_bad++; $display("FAIL k3_finished: got %0d want 1", fin_cnt + extra_fin); end
   endtask

   task automatic test_k4_extreme();
      longint want;
      want = (longint'(1) << 50) + 8388607;
      clear_mems();
      for (int n = 0; n < R * C; n++) xmem[n] = 24'sh800000;
      for (int n = 0; n < 16; n++) wmem[n] = 24'sh800000;
      run_job(4, 8388607, 100, -1);
      n_cmp++; if (got_q.size() != 30) begin n_bad++; $display("FAIL k4_count: got %0d want 30", got_q.size()); end
      for (int n = 0; n < got_q.size(); n++) begin
         n_cmp++;
         if (got_q[n] != want) begin n_bad++; $display("FAIL k4_out[%0d]: got %0d want %0d", n, got_q[n], want); end
      end
      n_cmp++; if (first_valid - 1 != 18) begin n_bad++; $display("FAIL k4_latency: got %0d want 18", first_valid - 1); end
   endtask

   task automatic test_k2_random_stall();
      longint b;
      clear_mems();
      for (int n = 0; n < R * C; n++) xmem[n] = INW'($urandom);
      for (int n = 0; n < 4; n++) wmem[n] = INW'($urandom);
      b = longint'($signed(INW'($urandom)));
      calc_golden(2, b);
      run_job(2, b, 30, -1);
      n_cmp++; if (got_q.size() != exp_q.size()) begin n_bad++; $display("FAIL k2_count: got %0d want %0d", got_q.size(), exp_q.size()); end
      for (int n = 0; n < got_q.size() && n < exp_q.size(); n++) begin
         n_cmp++;
         if (got_q[n] != exp_q[n]) begin n_bad++; $display("FAIL k2_out[%0d]: got %0d want %0d", n, got_q[n], exp_q[n]); end
      end
      n_cmp++; if (stall_err != 0) begin n_bad++; $display("FAIL k2_stall_stable: got %0d changes want 0", stall_err); end
      n_cmp++; if (fin_cnt != 1 || extra_fin != 0) begin n_bad++; $display("FAIL k2_finished: got %0d want 1", fin_cnt + extra_fin); end
   endtask

   task automatic test_reset_mid_run();
      longint b;
      int     bad_fin, bad_valid;
      clear_mems();
      for (int n = 0; n < R * C; n++) xmem[n] = INW'($urandom);
      for (int n = 0; n < 4; n++) wmem[n] = INW'($urandom);
      b = longint'($signed(INW'($urandom)));
      run_job(2, b, 100, 4);
      n_cmp++; if (!aborted) begin n_bad++; $display("FAIL abort_reached: got %0d outputs want abort after 4", got_q.size()); end
      @(negedge clk);
      n_cmp++; if (AXIS_TVALID !== 1'b0) begin n_bad++; $display("FAIL abort_tvalid: got %b want 0", AXIS_TVALID); end
      n_cmp++; if (compute_finished !== 1'b0) begin n_bad++; $display("FAIL abort_finished: got %b want 0", compute_finished); end
      reset = 1'b0;
      bad_fin = 0; bad_valid = 0;
      for (int n = 0; n < 10; n++) begin
         @(negedge clk);
         if (compute_finished === 1'b1) bad_fin++;
         if (AXIS_TVALID === 1'b1) bad_valid++;
      end
      n_cmp++; if (bad_fin != 0 || bad_valid != 0) begin n_bad++; $display("FAIL abort_quiet: got %0d pulses %0d valids want 0", bad_fin, bad_valid); end
      calc_golden(2, b);
      run_job(2, b, 100, -1);
      n_cmp++; if (got_q.size() != exp_q.size()) begin n_bad++; $display("FAIL rerun_count: got %0d want %0d", got_q.size(), exp_q.size()); end
      for (int n = 0; n < got_q.size() && n < exp_q.size(); n++) begin
         n_cmp++;
         if (got_q[n] != exp_q[n]) begin n_bad++; $display("FAIL rerun_out[%0d]: got %0d want %0d", n, got_q[n], exp_q[n]); end
      end
   endtask

   task automatic test_k0();
      run_job(0, 7, 100, -1);
      n_cmp++; if (got_q.size() != 0 || first_valid != -1) begin n_bad++; $display("FAIL k0_no_output: got %0d outputs want 0", got_q.size()); end
      n_cmp++; if (fin_cnt != 1) begin n_bad++; $display("FAIL k0_finished: got %0d want 1", fin_cnt); end
      n_cmp++; if (extra_fin != 0 || extra_valid != 0) begin n_bad++; $display("FAIL k0_release_hold: got %0d pulses %0d valids want 0", extra_fin, extra_valid); end
   endtask

   initial begin
      clear_mems();
      test_reset();
      test_k1_ramp();
      test_k3_latency();
      test_k4_extreme();
      test_k2_random_stall();
      test_reset_mid_run();
      test_k0();
      // a normal job after the K=0 run shows RELEASE returned to IDLE
      test_k3_latency();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no completion want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
